decompress_feeder: RTL

DECOMPRESS_FEEDER -- requirements
Module: decompress_feeder

---
 rtl/decompress_pkg.sv | 14 +
 rtl/bit_index_advance.sv | 17 +
 rtl/decompress_feeder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/decompress_pkg.sv
// decompress_pkg: shared FSM states, record geometry and record field positions
package decompress_pkg;
  typedef enum logic [3:0] {IDLE, RD0, W0, RD1, W1, ISSUE, WDONE, WLOW, ADV, FIN} state_t;
  localparam int REC_BYTES = 2;
  localparam int LEN_MSB = 6;
  localparam int LEN_LSB = 0;
  localparam int VAL_BIT = 7;
  function automatic logic [LEN_MSB-LEN_LSB:0] rec_len(input logic [7:0] b);
    return b[LEN_MSB:LEN_LSB];
  endfunction
  function automatic logic rec_val(input logic [7:0] b);
    return b[VAL_BIT];
  endfunction
endpackage

// File: rtl/bit_index_advance.sv
// bit_index_advance: next write position after emitting len bits
// ports: byte_i/bit_i current position (bit 7 = MSB), len_i run length,
//        byte_o/bit_o position after the run
module bit_index_advance (
  input  logic [31:0] byte_i,
  input  logic [2:0]  bit_i,
  input  logic [6:0]  len_i,
  output logic [31:0] byte_o,
  output logic [2:0]  bit_o
);
  logic [7:0] span;
  always_comb begin
    span = 8'(3'd7 - bit_i) + 8'(len_i);
    bit_o = bit_i - len_i[2:0];
    byte_o = byte_i + 32'(span[7:3]);
  end
endmodule

// File: rtl/decompress_feeder.sv
// decompress_feeder: fetches 2-byte run-length records and feeds them to a bit-writer handler
// ports: clk/RST clock and sync reset; start/src_base/rec_count/dst_byte/dst_bit job setup;
//        mem_rd/mem_addr/mem_rdata/mem_rvalid record memory; in1/in2/byteIndx/bitIndx/work/
//        working/done_in handler handshake; busy/finished/err/total_bits job status
module decompress_feeder
  import decompress_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [15:0]       rec_count,
  input  logic [31:0]       dst_byte,
  input  logic [2:0]        dst_bit,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        in1,
  output logic [7:0]        in2,
  output logic [31:0]       byteIndx,
  output logic [2:0]        bitIndx,
  output logic              work,
  output logic              working,
  input  logic              done_in,
  output logic              busy,
  output logic              finished,
  output logic              err,
  output logic [31:0]       total_bits
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [15:0] cnt_q, i_q;
  logic [TW-1:0] tmr_q;
  logic [7:0] in1_q, in2_q;
  logic [31:0] byte_q, total_q, byte_nx;
  logic [2:0] bit_q, bit_nx;
  logic err_q, tmo, waiting;
  logic [6:0] len;
  assign len = rec_len(in1_q);
  assign waiting = state_q inside {WDONE, WLOW};
  assign tmo = tmr_q == TW'(TIMEOUT - 1);
  bit_index_advance u_adv (
    .byte_i(byte_q),
    .bit_i(bit_q),
    .len_i(len),
    .byte_o(byte_nx),
    .bit_o(bit_nx)
  );
  always_ff @(posedge clk) state_q <= RST ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = rec_count == 16'd0 ? FIN : RD0;
      RD0:     state_d = W0;
      W0:      if (mem_rvalid) state_d = RD1;
      RD1:     state_d = W1;
      W1:      if (mem_rvalid) state_d = len == 7'd0 ? ADV : ISSUE;
      ISSUE:   state_d = WDONE;
      WDONE:   state_d = done_in ? WLOW : tmo ? FIN : WDONE;
      WLOW:    state_d = !done_in ? ADV : tmo ? FIN : WLOW;
      ADV:     state_d = i_q + 16'd1 < cnt_q ? RD0 : FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_rd = state_q inside {RD0, RD1};
    mem_addr = base_q + ADDR_W'(32'(i_q) * REC_BYTES) + ADDR_W'(state_q == RD1);
    work = state_q inside {ISSUE, WDONE};
    working = work;
    busy = state_q != IDLE;
    finished = state_q == FIN;
  end
  // the wait timer restarts whenever the state changes, so WDONE and WLOW are timed separately
  always_ff @(posedge clk) begin
    if (RST) begin
      base_q <= '0;
      cnt_q <= '0;
      i_q <= '0;
      tmr_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      byte_q <= '0;
      bit_q <= '0;
      total_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= waiting && state_d == state_q ? tmr_q + 1'b1 : '0;
      if (state_q == IDLE && start) begin
        base_q <= src_base;
        cnt_q <= rec_count;
        i_q <= '0;
        byte_q <= dst_byte;
        bit_q <= dst_bit;
        total_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == W0 && mem_rvalid) in1_q <= mem_rdata;
      if (state_q == W1 && mem_rvalid) in2_q <= mem_rdata;
      if (waiting && state_d == FIN) err_q <= 1'b1;
      if (state_q == ADV) begin
        byte_q <= byte_nx;
        bit_q <= bit_nx;
        total_q <= total_q + 32'(len);
        i_q <= i_q + 16'd1;
      end
    end
  end
  assign in1 = in1_q;
  assign in2 = in2_q;
  assign byteIndx = byte_q;
  assign bitIndx = bit_q;
  assign err = err_q;
  assign total_bits = total_q;
endmodule
